// File: rtl/crop_pkg.sv
// crop_pkg: sequencer state encoding and default frame/crop geometry
package crop_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, COLLECT, NEXT, DONE} crop_seq_state_t;
  localparam int IN_ROWS = 100;
  localparam int IN_COLS = 160;
  localparam int OUT_ROWS = 48;
  localparam int OUT_COLS = 48;
endpackage

// File: rtl/crop_res_reg.sv
// crop_res_reg: one-entry valid/ready holding register for the merged result stream
module crop_res_reg #(
  parameter int W = 16,
  parameter int UW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic          in_last,
  input  logic [UW-1:0] in_user,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic          out_last,
  output logic [UW-1:0] out_user
);
  logic          valid_q, valid_d, load;
  logic [W+UW:0] pay_q, pay_d;
  assign in_ready = !valid_q || out_ready;
  assign load = in_valid && in_ready;
  always_comb begin
    valid_d = load ? 1'b1 : out_ready ? 1'b0 : valid_q;
    pay_d = load ? {in_data, in_last, in_user} : pay_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pay_q <= '0;
    end else begin
      valid_q <= valid_d;
      pay_q <= pay_d;
    end
  end
  assign out_valid = valid_q;
  assign {out_data, out_last, out_user} = pay_q;
endmodule

// File: rtl/crop_sequencer.sv
// crop_sequencer: launches the crop datapath per window and merges its CNN channels into one result stream
module crop_sequencer #(
  parameter int PIXEL_BIT_WIDTH = 16,
  parameter int IN_ROWS = crop_pkg::IN_ROWS,
  parameter int IN_COLS = crop_pkg::IN_COLS,
  parameter int OUT_ROWS = crop_pkg::OUT_ROWS,
  parameter int OUT_COLS = crop_pkg::OUT_COLS,
  parameter int NUM_CROPS = 4,
  parameter int NUM_OUTPUTS = 5,
  parameter int YW = $clog2(IN_ROWS),
  parameter int XW = $clog2(IN_COLS),
  parameter int CW = NUM_CROPS > 1 ? $clog2(NUM_CROPS) : 1
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst_n,
  input  logic                                   ap_start,
  output logic                                   ap_done,
  output logic                                   ap_idle,
  output logic                                   ap_ready,
  input  logic [NUM_CROPS*YW-1:0]                cfg_y1,
  input  logic [NUM_CROPS*XW-1:0]                cfg_x1,
  output logic                                   dp_start,
  input  logic                                   dp_done,
  output logic [YW-1:0]                          dp_y1,
  output logic [XW-1:0]                          dp_x1,
  input  logic [NUM_OUTPUTS*PIXEL_BIT_WIDTH-1:0] cnn_output_TDATA,
  input  logic [NUM_OUTPUTS-1:0]                 cnn_output_TVALID,
  output logic [NUM_OUTPUTS-1:0]                 cnn_output_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]             res_TDATA,
  output logic                                   res_TVALID,
  input  logic                                   res_TREADY,
  output logic                                   res_TLAST,
  output logic [CW-1:0]                          res_TUSER,
  output logic                                   err_sticky
);
  import crop_pkg::*;
  localparam int SW = $clog2(NUM_OUTPUTS + 1);
  crop_seq_state_t            state_q, state_d;
  logic [CW-1:0]              crop_idx_q, crop_idx_d;
  logic [SW-1:0]              sel_q, sel_d;
  logic                       done_seen_q, done_seen_d, err_q, err_d;
  logic [NUM_CROPS*YW-1:0]    y1_q, y1_d;
  logic [NUM_CROPS*XW-1:0]    x1_q, x1_d;
  logic                       fits, accept, in_ready, all_in;
  logic [PIXEL_BIT_WIDTH-1:0] word;
  assign dp_y1 = y1_q[crop_idx_q*YW +: YW];
  assign dp_x1 = x1_q[crop_idx_q*XW +: XW];
  assign fits = 32'(dp_y1) + OUT_ROWS <= IN_ROWS && 32'(dp_x1) + OUT_COLS <= IN_COLS;
  assign ap_idle = state_q == IDLE;
  assign ap_ready = ap_idle && ap_start;
  assign ap_done = state_q == DONE;
  assign dp_start = state_q == LAUNCH && fits;
  assign err_sticky = err_q;
  // sel walks 0..NUM_OUTPUTS; at NUM_OUTPUTS no channel is offered while dp_done is awaited
  always_comb begin
    word = '0;
    cnn_output_TREADY = '0;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      cnn_output_TREADY[k] = state_q == COLLECT && sel_q == SW'(k) && in_ready;
      word = sel_q == SW'(k) ? cnn_output_TDATA[k*PIXEL_BIT_WIDTH +: PIXEL_BIT_WIDTH] : word;
    end
  end
  assign accept = |(cnn_output_TVALID & cnn_output_TREADY);
  assign all_in = sel_q == SW'(NUM_OUTPUTS) || (accept && sel_q == SW'(NUM_OUTPUTS - 1));
  always_comb begin
    state_d = state_q;
    crop_idx_d = crop_idx_q;
    sel_d = sel_q;
    done_seen_d = done_seen_q;
    err_d = err_q;
    y1_d = y1_q;
    x1_d = x1_q;
    case (state_q)
      IDLE: if (ap_start) begin
        y1_d = cfg_y1;
        x1_d = cfg_x1;
        err_d = 1'b0;
        crop_idx_d = '0;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        sel_d = '0;
        done_seen_d = 1'b0;
        err_d = err_q || !fits;
        state_d = fits ? COLLECT : NEXT;
      end
      COLLECT: begin
        sel_d = sel_q + SW'(accept);
        done_seen_d = done_seen_q || dp_done;
        state_d = all_in && done_seen_d ? NEXT : COLLECT;
      end
      NEXT: if (crop_idx_q != CW'(NUM_CROPS - 1)) begin
        crop_idx_d = crop_idx_q + 1'b1;
        state_d = LAUNCH;
      end else if (!res_TVALID) begin
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      crop_idx_q <= '0;
      sel_q <= '0;
      done_seen_q <= 1'b0;
      err_q <= 1'b0;
      y1_q <= '0;
      x1_q <= '0;
    end else begin
      state_q <= state_d;
      crop_idx_q <= crop_idx_d;
      sel_q <= sel_d;
      done_seen_q <= done_seen_d;
      err_q <= err_d;
      y1_q <= y1_d;
      x1_q <= x1_d;
    end
  end
  crop_res_reg #(.W(PIXEL_BIT_WIDTH), .UW(CW)) u_res (
    .clk(ap_clk),
    .rst_n(ap_rst_n),
    .in_valid(accept),
    .in_ready(in_ready),
    .in_data(word),
    .in_last(sel_q == SW'(NUM_OUTPUTS - 1)),
    .in_user(crop_idx_q),
    .out_valid(res_TVALID),
    .out_ready(res_TREADY),
    .out_data(res_TDATA),
    .out_last(res_TLAST),
    .out_user(res_TUSER)
  );
endmodule

// File: tb/tb_crop_sequencer.sv
// tb_crop_sequencer: randomized scoreboard bench for crop_sequencer
module tb_crop_sequencer;
  localparam int PW = 16, NR = 100, NCOL = 160, OROWS = 48, OCOLS = 48, NC = 4, NO = 5;
  localparam int YW = $clog2(NR), XW = $clog2(NCOL), CW = $clog2(NC);
  typedef struct packed {logic [PW-1:0] d; logic l; logic [CW-1:0] u;} word_t;
  typedef struct {int c; int y; int x;} launch_t;
  logic ap_clk = 0, ap_rst_n = 0, ap_start = 0, dp_done = 0, res_TREADY = 1;
  logic ap_done, ap_idle, ap_ready, dp_start, res_TVALID, res_TLAST, err_sticky;
  logic [NC*YW-1:0] cfg_y1 = '0;
  logic [NC*XW-1:0] cfg_x1 = '0;
  logic [YW-1:0] dp_y1;
  logic [XW-1:0] dp_x1;
  logic [NO*PW-1:0] cnn_output_TDATA = '0;
  logic [NO-1:0] cnn_output_TVALID = '0, cnn_output_TREADY;
  logic [PW-1:0] res_TDATA;
  logic [CW-1:0] res_TUSER;
  int checks = 0, failures = 0, done_cnt = 0, ready_cnt = 0, nwords = 0, launches = 0;
  int stall_left = 0, rdy_mode = 0, dp_mode = 0;
  bit abort = 0, dp_busy = 0;
  int cy[NC], cx[NC];
  word_t exp_q[$];
  launch_t launch_q[$];

  crop_sequencer #(.PIXEL_BIT_WIDTH(PW), .IN_ROWS(NR), .IN_COLS(NCOL), .OUT_ROWS(OROWS), .OUT_COLS(OCOLS),
                   .NUM_CROPS(NC), .NUM_OUTPUTS(NO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .ap_ready(ap_ready), .cfg_y1(cfg_y1), .cfg_x1(cfg_x1), .dp_start(dp_start), .dp_done(dp_done),
    .dp_y1(dp_y1), .dp_x1(dp_x1), .cnn_output_TDATA(cnn_output_TDATA), .cnn_output_TVALID(cnn_output_TVALID),
    .cnn_output_TREADY(cnn_output_TREADY), .res_TDATA(res_TDATA), .res_TVALID(res_TVALID),
    .res_TREADY(res_TREADY), .res_TLAST(res_TLAST), .res_TUSER(res_TUSER), .err_sticky(err_sticky)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    chk({tag, "_ap_done"}, ap_done, 0);
    chk({tag, "_ap_ready"}, ap_ready, 0);
    chk({tag, "_ap_idle"}, ap_idle, 1);
    chk({tag, "_dp_start"}, dp_start, 0);
    chk({tag, "_dp_y1"}, dp_y1, 0);
    chk({tag, "_dp_x1"}, dp_x1, 0);
    chk({tag, "_cnn_tready"}, cnn_output_TREADY, 0);
    chk({tag, "_res_tvalid"}, res_TVALID, 0);
    chk({tag, "_res_tdata"}, res_TDATA, 0);
    chk({tag, "_res_tlast"}, res_TLAST, 0);
    chk({tag, "_res_tuser"}, res_TUSER, 0);
    chk({tag, "_err_sticky"}, err_sticky, 0);
  endtask

  // result sink: back-pressure source
  initial forever begin
    @(posedge ap_clk);
    #1;
    if (stall_left > 0) begin
      res_TREADY = 1'b0;
      stall_left--;
    end else res_TREADY = rdy_mode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
  end

  // monitor: pops the scoreboard on every result handshake, checks holding while stalled
  initial begin
    word_t got, held, e;
    bit stall = 0;
    held = '0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        stall = 0;
        continue;
      end
      got = {res_TDATA, res_TLAST, res_TUSER};
      if (stall) chk("stall_hold", {res_TVALID, got}, {1'b1, held});
      if (ap_done) done_cnt++;
      if (ap_ready) ready_cnt++;
      if (res_TVALID && res_TREADY) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_word: got word %0h, expected no word", got);
        end else begin
          e = exp_q.pop_front();
          chk("res_word", got, e);
          nwords++;
        end
      end
      stall = res_TVALID && !res_TREADY;
      held = got;
    end
  end

  // datapath model for one crop: channel k carries 100*crop+k, dp_done timing chosen by dp_mode
  task automatic serve(input int c, input int y, input int x);
    logic [NO-1:0] pend, acc;
    int vd, dd, cyc;
    bit ds;
    pend = '1;
    cyc = 0;
    ds = 0;
    vd = dp_mode == 1 ? 3 : $urandom_range(0, 4);
    dd = $urandom_range(0, 12);
    dp_busy = 1;
    for (int k = 0; k < NO; k++) cnn_output_TDATA[k*PW +: PW] = PW'(100 * c + k);
    @(negedge ap_clk);
    while ((pend != 0 || !ds) && !abort) begin
      dp_done = 0;
      cnn_output_TVALID = cyc >= vd ? pend : '0;
      acc = cnn_output_TVALID & cnn_output_TREADY;
      if (!ds && ((dp_mode == 0 && cyc >= dd) || (dp_mode == 1 && cyc == 0) || (dp_mode == 2 && acc[NO-1]))) begin
        dp_done = 1;
        ds = 1;
      end
      pend &= ~acc;
      chk("dp_origin_hold", {dp_y1, dp_x1}, {YW'(y), XW'(x)});
      @(negedge ap_clk);
      cyc++;
      if (cyc > 3000) begin
        checks++;
        failures++;
        $display("FAIL crop_collect_timeout: pending %0b after %0d cycles, expected drained", pend, cyc);
        break;
      end
    end
    dp_done = 0;
    cnn_output_TVALID = '0;
    dp_busy = 0;
  endtask

  initial begin
    launch_t l;
    forever begin
      @(negedge ap_clk);
      if (ap_rst_n && dp_start) begin
        launches++;
        if (launch_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_dp_start: got dp_start at y=%0d x=%0d, expected none", dp_y1, dp_x1);
        end else begin
          l = launch_q.pop_front();
          chk("dp_y1", dp_y1, l.y);
          chk("dp_x1", dp_x1, l.x);
          serve(l.c, l.y, l.x);
        end
      end
    end
  end

  task automatic mid_reset(input string tag);
    int d0;
    abort = 1;
    ap_start = 0;
    ap_rst_n = 0;
    #1;
    check_rst({tag, "_async"});
    exp_q.delete();
    launch_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge ap_clk);
    for (int i = 0; i < 20 && dp_busy; i++) @(negedge ap_clk);
    chk({tag, "_dp_quiet"}, dp_busy, 0);
    chk({tag, "_no_done_in_reset"}, done_cnt - d0, 0);
    ap_rst_n = 1;
    abort = 0;
    repeat (3) @(negedge ap_clk);
    chk({tag, "_idle_after"}, ap_idle, 1);
    chk({tag, "_no_done_after"}, done_cnt - d0, 0);
  endtask

  task automatic do_run(input string tag, input bit poke, input bit rst_mid);
    int d0, r0, nexp, after;
    bit experr, got;
    nexp = 0;
    after = 0;
    experr = 0;
    got = 0;
    nwords = 0;
    for (int k = 0; k < NC; k++) begin
      if (cy[k] + OROWS <= NR && cx[k] + OCOLS <= NCOL) begin
        launch_q.push_back('{k, cy[k], cx[k]});
        for (int j = 0; j < NO; j++) begin
          exp_q.push_back({PW'(100 * k + j), j == NO - 1, CW'(k)});
          nexp++;
        end
      end else experr = 1;
    end
    @(posedge ap_clk);
    #1;
    for (int k = 0; k < NC; k++) begin
      cfg_y1[k*YW +: YW] = YW'(cy[k]);
      cfg_x1[k*XW +: XW] = XW'(cx[k]);
    end
    ap_start = 1;
    launches = 0;
    d0 = done_cnt;
    r0 = ready_cnt;
    #1;
    chk({tag, "_ap_ready"}, ap_ready, 1);
    chk({tag, "_idle_at_start"}, ap_idle, 1);
    @(posedge ap_clk);
    #1;
    ap_start = 0;
    chk({tag, "_left_idle"}, ap_idle, 0);
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge ap_clk);
      got = ap_done;
      ap_start = poke && launches == 1;
      if (rst_mid && launches >= 2) begin
        after++;
        if (after == 3) begin
          mid_reset(tag);
          return;
        end
      end
    end
    ap_start = 0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_ap_done: got no ap_done in 3000 cycles, expected one", tag);
    end else begin
      chk({tag, "_err_sticky"}, err_sticky, experr);
      chk({tag, "_word_count"}, nwords, nexp);
      chk({tag, "_words_left"}, exp_q.size(), 0);
      chk({tag, "_launches_left"}, launch_q.size(), 0);
      repeat (4) @(negedge ap_clk);
      chk({tag, "_done_pulses"}, done_cnt - d0, 1);
      chk({tag, "_ready_pulses"}, ready_cnt - r0, 1);
      chk({tag, "_idle_end"}, ap_idle, 1);
    end
    exp_q.delete();
    launch_q.delete();
  endtask

  task automatic set_all(input int y, input int x);
    for (int k = 0; k < NC; k++) begin
      cy[k] = y;
      cx[k] = x;
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    #12;
    check_rst("por");
    @(negedge ap_clk);
    ap_rst_n = 1;
    set_all(10, 10);
    do_run("basic", 0, 0);
    cy[2] = 60;
    do_run("skip", 0, 0);
    for (int k = 0; k < NC; k++) begin
      cy[k] = $urandom_range(0, 60);
      cx[k] = $urandom_range(0, 120);
    end
    cy[0] = 10;
    cx[0] = 10;
    rdy_mode = 1;
    stall_left = 50;
    do_run("stall", 0, 0);
    set_all(52, 112);
    dp_mode = 1;
    do_run("early_done", 0, 0);
    dp_mode = 2;
    do_run("late_done", 0, 0);
    dp_mode = 0;
    set_all(20, 30);
    do_run("start_in_collect", 1, 0);
    set_all(10, 10);
    do_run("rst_mid", 0, 1);
    do_run("restart", 0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < NC; k++) begin
        cy[k] = $urandom_range(0, 58);
        cx[k] = $urandom_range(0, 116);
      end
      dp_mode = $urandom_range(0, 2);
      do_run("random", 0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
